riscv_test_monitor: RTL
=======================

// Module: riscv_test_monitor
// PURPOSE
//  Synthesizable pass/fail monitor for riscv-tests runs; replaces per-test hard-coded bench checks.
//  Sits beside Core, snoops fetch PC and register-file write port, tracks the result register, detects end-of-test.
//  Reports PASS/FAIL/TIMEOUT with failing test number and cycle count; one instance serves every rv32*-p-* test.
// PARAMETERS
//  XLEN           32        data/address width
//  DONE_PC        32'h44    fetch PC marking end of test (pass/fail trap target)
//  RESULT_REG     3         architectural register holding result (gp); 1..31
//  PASS_VALUE     1         result value meaning pass
//  SETTLE_CYCLES  4         cycles waited after DONE_PC so in-flight writebacks land; 0..15
//  TIMEOUT_CYCLES 6000      run-cycle limit before TIMEOUT; >=1
//  TOHOST_ADDR    32'h1000  store address for tohost detection (TOHOST_EN only)
// PORTS
//  clk          in   1     clock
//  rst          in   1     asynchronous active-high reset
//  start        in   1     1-cycle pulse: clear results, begin RUN
//  pc           in   XLEN  fetch PC (if_pc)
//  pc_valid     in   1     pc is a real fetch this cycle (not bubble/stall)
//  rd_we        in   1     register-file write enable
//  rd_addr      in   5     register-file write index
//  rd_wdata     in   XLEN  register-file write data
//  st_we        in   1     data-memory store strobe (used only with TOHOST_EN)
//  st_addr      in   XLEN  store address (TOHOST_EN only)
//  st_wdata     in   XLEN  store data (TOHOST_EN only)
//  busy         out  1     RUN or SETTLE
//  done         out  1     sticky: verdict available
//  pass         out  1     sticky: verdict pass
//  fail         out  1     sticky: verdict fail (value mismatch or timeout)
//  timeout      out  1     sticky: verdict caused by cycle limit
//  fail_code    out  XLEN  result value at verdict (XLEN'b0 on pass/timeout)
//  cycle_count  out  32    cycles spent in RUN+SETTLE, saturating at 32'hFFFF_FFFF
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE; busy/done/pass/fail/timeout=0; fail_code=0; cycle_count=0; shadow=0.
//  States: IDLE -> RUN on start; RUN -> SETTLE on pc_valid && pc==DONE_PC; RUN -> VERDICT on timeout;
//   SETTLE -> VERDICT after SETTLE_CYCLES cycles (SETTLE_CYCLES=0: straight to VERDICT next cycle); VERDICT -> IDLE.
//  Shadow: in RUN/SETTLE, rd_we && rd_addr==RESULT_REG loads rd_wdata same edge; writes to x0 never tracked.
//  Verdict edge: done=1; pass=(shadow==PASS_VALUE); fail=!pass; fail_code=pass?0:shadow. Verdict uses shadow
//   including any write on the final SETTLE cycle. Outputs visible the cycle after entering VERDICT, held until start/rst.
//  cycle_count: cleared on start, +1 every RUN/SETTLE cycle, frozen in IDLE.
//  Timeout: cycle_count reaching TIMEOUT_CYCLES in RUN -> timeout=1, fail=1, fail_code=0. DONE_PC in same cycle wins (go SETTLE).
//   Timer not checked in SETTLE.
//  start while busy: restart — clear outputs, shadow, counter; re-enter RUN. start in IDLE/after verdict: same.
//  pc==DONE_PC with pc_valid=0 ignored; DONE_PC outside RUN ignored.
//  rst mid-run: immediate return to reset values; no verdict emitted.
// CONFIGURATION
//  TOHOST_EN defined: in RUN, st_we && st_addr==TOHOST_ADDR && st_wdata!=0 ends test directly (skips SETTLE):
//   st_wdata==1 -> pass; else fail, fail_code=st_wdata>>1 (test number). Beats DONE_PC/timeout same cycle.
//  TOHOST_EN undefined: st_* ports present but ignored; only DONE_PC + shadow decide verdict.
// TESTING
//  start; write x3=1 at cycle 5; pc=32'h44 valid at cycle 10 -> after 4 settle cycles done=1,pass=1,fail_code=0.
//  start; x3=1, then DONE_PC, then x3=7 on 2nd SETTLE cycle -> fail=1, fail_code=7 (late writeback honoured).
//  start; never reach DONE_PC -> at cycle_count=6000 done=1,fail=1,timeout=1,fail_code=0.
//  start; rd_we x0 with 1, pc=32'h44 with pc_valid=0 -> no effect; still busy until timeout.
//  start; mid-SETTLE assert rst 1 ns (off-edge) -> all outputs 0 immediately; new start runs clean pass.
//  TOHOST_EN: store 32'h0000_000B to TOHOST_ADDR -> next cycle done=1,fail=1,fail_code=5; store 1 -> pass=1.

Source files
------------

// File: rtl/riscv_test_monitor_if.sv
// Bus bundle between a core-side driver (master) and riscv_test_monitor (slave):
// fetch/writeback/store snoop inputs plus the verdict outputs.
interface riscv_test_monitor_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            rd_we;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_wdata;
  logic            st_we;
  logic [XLEN-1:0] st_addr;
  logic [XLEN-1:0] st_wdata;
  logic            busy;
  logic            done;
  logic            pass;
  logic            fail;
  logic            timeout;
  logic [XLEN-1:0] fail_code;
  logic [31:0]     cycle_count;

  modport master (
    output start, pc, pc_valid, rd_we, rd_addr, rd_wdata, st_we, st_addr, st_wdata,
    input  busy, done, pass, fail, timeout, fail_code, cycle_count
  );

  modport slave (
    input  start, pc, pc_valid, rd_we, rd_addr, rd_wdata, st_we, st_addr, st_wdata,
    output busy, done, pass, fail, timeout, fail_code, cycle_count
  );
endinterface

// File: rtl/riscv_test_monitor.sv
// Pass/fail/timeout monitor for riscv-tests runs: tracks the result register and end-of-test PC.
// Optional macro TOHOST_EN: a non-zero store to TOHOST_ADDR ends the test directly.
module riscv_test_monitor #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] DONE_PC        = 'h44,
  parameter int              RESULT_REG     = 3,
  parameter logic [XLEN-1:0] PASS_VALUE     = 'h1,
  parameter int              SETTLE_CYCLES  = 4,
  parameter int              TIMEOUT_CYCLES = 6000,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = 'h1000
) (
  input logic                  clk,
  input logic                  rst,
  riscv_test_monitor_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, SETTLE, VERDICT} state_t;

  state_t          state, state_nxt;
  logic [3:0]      settle_cnt;
  logic [XLEN-1:0] shadow;
  logic            to_flag;
  logic            th_flag;
  logic [XLEN-1:0] th_val;
  logic            busy_c;
  logic            done_r, pass_r, fail_r, timeout_r;
  logic [XLEN-1:0] fail_code_r;
  logic [31:0]     cycle_count_r;

  logic            done_pc_hit;
  logic            timer_hit;
  logic            settle_last;
  logic            rd_hit;
  logic            tohost_hit;
  logic [XLEN-1:0] tohost_data;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign done_pc_hit = bus.pc_valid && (bus.pc == DONE_PC);
  // This RUN cycle is the TIMEOUT_CYCLES-th one: counter lands exactly on the limit.
  assign timer_hit   = (cycle_count_r >= 32'(TIMEOUT_CYCLES - 1));
  assign settle_last = (settle_cnt == 4'(SETTLE_CYCLES - 1));
  assign rd_hit      = bus.rd_we && (bus.rd_addr == 5'(RESULT_REG)) && (bus.rd_addr != 5'd0);

`ifdef TOHOST_EN
  assign tohost_hit  = bus.st_we && (bus.st_addr == TOHOST_ADDR) && (bus.st_wdata != '0);
  assign tohost_data = bus.st_wdata;
`else
  logic unused_st;
  assign unused_st   = ^{bus.st_we, bus.st_addr, bus.st_wdata, TOHOST_ADDR};
  assign tohost_hit  = 1'b0;
  assign tohost_data = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RUN: begin
          if (tohost_hit)       state_nxt = VERDICT;
          else if (done_pc_hit) state_nxt = (SETTLE_CYCLES == 0) ? VERDICT : SETTLE;
          else if (timer_hit)   state_nxt = VERDICT;
        end
        SETTLE:  if (settle_last) state_nxt = VERDICT;
        VERDICT: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_c = (state == RUN) || (state == SETTLE);
  end

  // Tracking / verdict registers; the verdict is latched while in VERDICT so a
  // writeback on the last SETTLE cycle is already in the shadow copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt    <= '0;
      shadow        <= '0;
      to_flag       <= 1'b0;
      th_flag       <= 1'b0;
      th_val        <= '0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      fail_r        <= 1'b0;
      timeout_r     <= 1'b0;
      fail_code_r   <= '0;
      cycle_count_r <= '0;
    end else if (bus.start) begin
      settle_cnt    <= '0;
      shadow        <= '0;
      to_flag       <= 1'b0;
      th_flag       <= 1'b0;
      th_val        <= '0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      fail_r        <= 1'b0;
      timeout_r     <= 1'b0;
      fail_code_r   <= '0;
      cycle_count_r <= '0;
    end else begin
      if (busy_c) begin
        cycle_count_r <= sat_inc(cycle_count_r);
        if (rd_hit) shadow <= bus.rd_wdata;
      end
      case (state)
        RUN: begin
          settle_cnt <= '0;
          to_flag    <= timer_hit && !done_pc_hit && !tohost_hit;
          th_flag    <= tohost_hit;
          th_val     <= tohost_data;
        end
        SETTLE: settle_cnt <= settle_cnt + 4'd1;
        VERDICT: begin
          done_r <= 1'b1;
          if (th_flag) begin
            pass_r      <= (th_val == XLEN'(1));
            fail_r      <= (th_val != XLEN'(1));
            timeout_r   <= 1'b0;
            fail_code_r <= (th_val == XLEN'(1)) ? '0 : (th_val >> 1);
          end else if (to_flag) begin
            pass_r      <= 1'b0;
            fail_r      <= 1'b1;
            timeout_r   <= 1'b1;
            fail_code_r <= '0;
          end else begin
            pass_r      <= (shadow == PASS_VALUE);
            fail_r      <= (shadow != PASS_VALUE);
            timeout_r   <= 1'b0;
            fail_code_r <= (shadow == PASS_VALUE) ? '0 : shadow;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_r;
  assign bus.pass        = pass_r;
  assign bus.fail        = fail_r;
  assign bus.timeout     = timeout_r;
  assign bus.fail_code   = fail_code_r;
  assign bus.cycle_count = cycle_count_r;

endmodule
